sum_frame_accum: RTL and testbench
==================================

// Module: sum_frame_accum
// PURPOSE
//  Downstream consumer of the W-bit ripple adder: takes its {cout,s} results (W+1 bits) as a
//  valid/ready stream and accumulates N_OPS of them into one frame total with sticky overflow.
//  Presents each total on a held valid/ready output port and counts completed frames.
//  Sits between the adder array and the result checker / display logic.
// PARAMETERS
//  W       2  adder operand width; in_data is W+1 bits (carry-out concatenated with sum)
//  N_OPS   4  operands per frame, >=1
//  ACC_W   4  accumulator width; must be >= W+1, otherwise elaboration error
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  clr        in   1       synchronous frame abort
//  in_valid   in   1       in_data valid
//  in_ready   out  1       block can accept in_data
//  in_data    in   W+1     {cout,s} from upstream adder, unsigned
//  out_valid  out  1       frame total valid
//  out_ready  in   1       consumer accepts total
//  out_sum    out  ACC_W   frame total modulo 2^ACC_W
//  out_ovf    out  1       some add in the frame carried out of ACC_W
//  frame_cnt  out  8       completed-frame count, wraps 255->0
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, acc=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0,
//    frame_cnt=0. Any partial frame is discarded. in_ready=1, since it is decoded from state.
//  States: IDLE, ACCUM, DONE. in_ready = (state != DONE), combinational from state only.
//  Accept = in_valid & in_ready.
//  IDLE + accept: acc<=zext(in_data), ovf<=0, cnt<=1; next=DONE if N_OPS==1, else ACCUM.
//  ACCUM + accept: {c,acc}<=acc+zext(in_data); ovf<=ovf|c; cnt<=cnt+1;
//    when cnt==N_OPS-1 next=DONE, else stay in ACCUM.
//  No accept in IDLE or ACCUM: all state holds. in_valid with no accept has no effect.
//  Entering DONE (registered): out_valid=1, out_sum=final acc, out_ovf=final ovf.
//    out_valid rises 1 cycle after the last operand is accepted.
//  DONE: in_ready=0. out_sum and out_ovf are held stable while out_valid & !out_ready.
//  DONE + out_ready: out_valid<=0, frame_cnt<=frame_cnt+1, next=IDLE, acc=0, cnt=0.
//    out_sum and out_ovf keep their last values.
//  Back-to-back throughput: N_OPS+1 cycles per frame. DONE costs one bubble; IDLE accepts
//    in the cycle immediately after the output handshake.
//  clr (sync) has priority over accept and handshake. It forces IDLE, acc=0, cnt=0, ovf=0,
//    out_valid=0. It leaves frame_cnt unchanged and clears out_sum/out_ovf to 0.
//  Arithmetic is unsigned. Wrap-around is modulo 2^ACC_W, with ovf sticky until the next frame.
//  cnt width is clog2(N_OPS+1).
// STRUCTURE
//  Shared package/include sum_pkg: state encodings SUM_IDLE=2'd0, SUM_ACCUM=2'd1,
//    SUM_DONE=2'd2, and the clog2 constant function.
//  One sub-module, accum_add: ACC_W-bit adder with carry-out, written as a ripple of
//    full-adder equations; its result feeds the acc/ovf registers.
//  Top level holds the FSM, cnt, acc/ovf, output registers and frame_cnt.
// TESTING  (W=2, N_OPS=4, ACC_W=4)
//  1. Reset, then operands 3,5,1,2 with out_ready=1 -> out_sum=4'd11, out_ovf=0,
//     out_valid high exactly 1 cycle after the 4th accept, frame_cnt=1.
//  2. Operands 7,7,7,7 -> out_sum=4'd12 (28 mod 16), out_ovf=1.
//  3. Frame 1,1,1,1 with out_ready=0 for 5 cycles and in_valid=1 throughout ->
//     in_ready=0, out_sum=4 held stable; no extra operand absorbed; the next frame starts clean.
//  4. Operands 3,4, then clr pulse, then 1,1,1,1 -> out_sum=4, out_ovf=0, frame_cnt unchanged by clr.
//  5. Operands 2,6, then rst_n low mid-cycle -> all outputs 0 immediately (async);
//     after release, 2,2,2,2 -> out_sum=8.
//  6. in_valid=1 and out_ready=1 continuously for 3 frames, the third being 0,0,0,7 ->
//     out_sum=7, frame_cnt=3, one in_ready=0 bubble per frame.

Source files
------------

// File: rtl/sum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sum_pkg
//  Description : Shared definitions for the frame accumulator. Holds the
//                FSM state encodings and a constant clog2 helper used to
//                size the operand counter.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package sum_pkg;

    localparam int SUM_STATE_W = 2;

    localparam logic [SUM_STATE_W-1:0] SUM_IDLE  = 2'd0;
    localparam logic [SUM_STATE_W-1:0] SUM_ACCUM = 2'd1;
    localparam logic [SUM_STATE_W-1:0] SUM_DONE  = 2'd2;

    // Smallest width that can represent values 0..value-1.
    function automatic int sum_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/accum_add.sv
`default_nettype none
// ============================================================================
//  Module      : accum_add
//  Description : Unsigned WIDTH-bit adder with carry-out, built as a ripple
//                chain of full-adder equations.
//  Ports       : a, b  - addends (WIDTH)
//                sum   - a + b modulo 2^WIDTH
//                cout  - carry out of the top bit
//  Revision    : 1.0  initial release
// ============================================================================
module accum_add #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = 1'b0;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/sum_frame_accum.sv
`default_nettype none
// ============================================================================
//  Module      : sum_frame_accum
//  Description : Accumulates N_OPS unsigned {cout,s} adder results from a
//                valid/ready stream into one frame total with sticky
//                overflow, presents the total on a held valid/ready port and
//                counts completed frames.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                clr             - synchronous frame abort
//                in_valid/ready  - operand handshake, in_data (W+1)
//                out_valid/ready - total handshake, out_sum (ACC_W), out_ovf
//                frame_cnt       - completed-frame count (8, wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module sum_frame_accum
    import sum_pkg::*;
#(
    parameter int W     = 2,
    parameter int N_OPS = 4,
    parameter int ACC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [7:0]       frame_cnt
);

    localparam int c_cnt_w = sum_clog2(N_OPS + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(N_OPS - 1);

    generate
        if (ACC_W < W + 1) begin : g_bad_acc_w
            $error("sum_frame_accum: ACC_W must be at least W+1");
        end
        if (N_OPS < 1) begin : g_bad_n_ops
            $error("sum_frame_accum: N_OPS must be at least 1");
        end
    endgenerate

    logic [SUM_STATE_W-1:0] r_state;
    logic [SUM_STATE_W-1:0] w_next_state;

    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;
    logic [7:0]         r_frame_cnt;

    logic               w_idle;
    logic               w_accept;
    logic               w_last_op;
    logic [ACC_W-1:0]   w_in_ext;
    logic [ACC_W-1:0]   w_add_a;
    logic [ACC_W-1:0]   w_add_sum;
    logic               w_add_cout;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_ovf_next;
    logic [c_cnt_w-1:0] w_cnt_next;

    assign w_idle   = (r_state == SUM_IDLE);
    assign w_accept = in_valid & in_ready;
    assign w_in_ext = ACC_W'(in_data);

    // The first operand of a frame adds onto zero, so the same adder path
    // serves both the frame start and the running accumulation; the carry
    // is necessarily zero in that case.
    assign w_add_a = w_idle ? '0 : r_acc;

    accum_add #(
        .WIDTH (ACC_W)
    ) u_accum_add (
        .a    (w_add_a),
        .b    (w_in_ext),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    assign w_acc_next = w_add_sum;
    assign w_ovf_next = w_idle ? 1'b0 : (r_ovf | w_add_cout);
    assign w_cnt_next = w_idle ? c_cnt_w'(1) : (r_cnt + c_cnt_w'(1));

    // True when the operand being accepted completes the frame.
    assign w_last_op = w_idle ? (N_OPS == 1) : (r_cnt == c_last_cnt);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SUM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        if (clr) begin
            w_next_state = SUM_IDLE;
        end else begin
            case (r_state)
                SUM_IDLE, SUM_ACCUM: begin
                    if (w_accept) begin
                        w_next_state = w_last_op ? SUM_DONE : SUM_ACCUM;
                    end
                end
                SUM_DONE: begin
                    if (out_ready) begin
                        w_next_state = SUM_IDLE;
                    end
                end
                default: w_next_state = SUM_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------- state output
    always_comb begin
        in_ready = (r_state != SUM_DONE);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else if (clr) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_ovf <= w_ovf_next;
            r_cnt <= w_cnt_next;
            if (w_last_op) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_acc_next;
                r_out_ovf   <= w_ovf_next;
            end
        end else if ((r_state == SUM_DONE) && out_ready) begin
            // Output handshake: out_sum/out_ovf keep their last values.
            r_out_valid <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_acc       <= '0;
            r_cnt       <= '0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sum_frame_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_frame_accum
//  Description : Self-checking bench for sum_frame_accum (W=2, N_OPS=4,
//                ACC_W=4). A frame-level reference model (queue of accepted
//                operands, integer total) predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sum_frame_accum;

    localparam int W     = 2;
    localparam int N_OPS = 4;
    localparam int ACC_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [W:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic [7:0]       frame_cnt;

    sum_frame_accum #(
        .W     (W),
        .N_OPS (N_OPS),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int bubbles  = 0;

    // Reference model: operands accepted so far in the open frame, whether
    // a total is waiting for the consumer, and the visible output values.
    int         m_ops[$];
    bit         m_pend;
    int         m_sum;
    bit         m_ovf;
    int         m_frames;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ops.delete();
        m_pend   = 1'b0;
        m_sum    = 0;
        m_ovf    = 1'b0;
        m_frames = 0;
    endtask

    // Predict the effect of the coming rising edge from the current inputs.
    task automatic model_edge();
        int total;
        if (clr) begin
            m_ops.delete();
            m_pend = 1'b0;
            m_sum  = 0;
            m_ovf  = 1'b0;
        end else if (m_pend) begin
            if (out_ready) begin
                m_pend   = 1'b0;
                m_frames = (m_frames + 1) % 256;
            end
        end else if (in_valid) begin
            m_ops.push_back(int'(in_data));
            if (m_ops.size() == N_OPS) begin
                total = 0;
                foreach (m_ops[i]) total += m_ops[i];
                m_sum  = total % (1 << ACC_W);
                m_ovf  = (total >= (1 << ACC_W));
                m_pend = 1'b1;
                m_ops.delete();
            end
        end
    endtask

    task automatic check_all(input string tag);
        if (!in_ready) bubbles++;
        chk({tag, "_in_ready"},  32'(in_ready),  32'(!m_pend));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_pend));
        chk({tag, "_out_sum"},   32'(out_sum),   32'(m_sum));
        chk({tag, "_out_ovf"},   32'(out_ovf),   32'(m_ovf));
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(m_frames));
    endtask

    // Called just after a falling edge: drive, predict, check at next fall.
    task automatic step(input string tag, input logic iv, input int d,
                        input logic ordy, input logic c);
        in_valid  = iv;
        in_data   = (W+1)'(d);
        out_ready = ordy;
        clr       = c;
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic feed4(input string tag, input int a, input int b,
                         input int c, input int d, input logic ordy);
        step(tag, 1'b1, a, ordy, 1'b0);
        step(tag, 1'b1, b, ordy, 1'b0);
        step(tag, 1'b1, c, ordy, 1'b0);
        step(tag, 1'b1, d, ordy, 1'b0);
    endtask

    // Reset asserted between clock edges; outputs must clear immediately.
    task automatic async_reset(input string tag);
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr       = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fc;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // 1: 3,5,1,2 -> 11, no overflow, then handshake.
        feed4("t1", 3, 5, 1, 2, 1'b1);
        chk("t1_sum_const", 32'(out_sum), 32'd11);
        chk("t1_valid_const", 32'(out_valid), 32'd1);
        step("t1h", 1'b0, 0, 1'b1, 1'b0);
        chk("t1_fc_const", 32'(frame_cnt), 32'd1);

        // 2: 7,7,7,7 -> 28 mod 16 = 12 with overflow.
        feed4("t2", 7, 7, 7, 7, 1'b1);
        chk("t2_sum_const", 32'(out_sum), 32'd12);
        chk("t2_ovf_const", 32'(out_ovf), 32'd1);
        step("t2h", 1'b0, 0, 1'b1, 1'b0);

        // 3: consumer stalls with in_valid held high.
        feed4("t3", 1, 1, 1, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("t3s", 1'b1, 3, 1'b0, 1'b0);
            chk("t3_stall_sum", 32'(out_sum), 32'd4);
        end
        step("t3h", 1'b1, 3, 1'b1, 1'b0);
        feed4("t3n", 2, 2, 2, 2, 1'b1);
        chk("t3_next_sum", 32'(out_sum), 32'd8);
        step("t3nh", 1'b0, 0, 1'b1, 1'b0);

        // 4: partial frame aborted by clr.
        fc = int'(frame_cnt);
        step("t4", 1'b1, 3, 1'b1, 1'b0);
        step("t4", 1'b1, 4, 1'b1, 1'b0);
        step("t4c", 1'b1, 5, 1'b1, 1'b1);
        feed4("t4", 1, 1, 1, 1, 1'b0);
        chk("t4_sum_const", 32'(out_sum), 32'd4);
        chk("t4_ovf_const", 32'(out_ovf), 32'd0);
        chk("t4_fc_kept", 32'(frame_cnt), 32'(fc));
        step("t4h", 1'b0, 0, 1'b1, 1'b0);

        // 5: async reset mid-frame, then a clean frame.
        step("t5", 1'b1, 2, 1'b1, 1'b0);
        step("t5", 1'b1, 6, 1'b1, 1'b0);
        async_reset("t5r");
        feed4("t5", 2, 2, 2, 2, 1'b1);
        chk("t5_sum_const", 32'(out_sum), 32'd8);
        step("t5h", 1'b0, 0, 1'b1, 1'b0);

        // 6: continuous traffic, three frames, one bubble each.
        async_reset("t6r");
        bubbles = 0;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) feed4("t6", 0, 0, 0, 7, 1'b1);
            else feed4("t6", $urandom_range(7), $urandom_range(7),
                       $urandom_range(7), $urandom_range(7), 1'b1);
            if (f == 2) chk("t6_sum_const", 32'(out_sum), 32'd7);
            step("t6b", 1'b1, 5, 1'b1, 1'b0);
        end
        chk("t6_fc_const", 32'(frame_cnt), 32'd3);
        chk("t6_bubbles", 32'(bubbles), 32'd3);

        // Randomized traffic with occasional aborts.
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(3) != 0), $urandom_range(7),
                 ($urandom_range(3) != 0), ($urandom_range(39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
